// File: rtl/lsq_id_alloc_ctrl_pkg.sv
// rtl/lsq_id_alloc_ctrl_pkg.sv - shared widths and FSM encoding for the LSQ free-ID controller
package lsq_id_alloc_ctrl_pkg;

  // Default geometry of the LSQ free-ID queue
  localparam int LSQ_IDW    = 4;
  localparam int LSQ_QDEPTH = 4;
  localparam int LSQ_CW     = $clog2(LSQ_QDEPTH + 1);

  // Sequencer states; encoding is shared with the queue-side tooling
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2
  } lsq_state_e;

endpackage

// File: rtl/lsq_rr_arb2.sv
// rtl/lsq_rr_arb2.sv - two-way round-robin arbiter with registered priority pointer
module lsq_rr_arb2
  import lsq_id_alloc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // ptr names the lane that wins the next contested cycle
  logic ptr;

  // Grant selection: uncontested lanes win outright, contests go to ptr
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // After a contest the pointer moves to the losing lane; uncontested grants leave it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (en && (req == 2'b11)) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/lsq_id_alloc_ctrl.sv
// rtl/lsq_id_alloc_ctrl.sv - LSQ free-ID queue sequencer: allocation arbitration, ID return, flush
module lsq_id_alloc_ctrl
  import lsq_id_alloc_ctrl_pkg::*;
#(
  parameter int IDW    = LSQ_IDW,
  parameter int QDEPTH = LSQ_QDEPTH,
  parameter int CW     = LSQ_CW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           alloc_req0,
  input  logic           alloc_req1,
  output logic           alloc_gnt0,
  output logic           alloc_gnt1,
  output logic [IDW-1:0] alloc_id,
  input  logic           rel_valid,
  input  logic [IDW-1:0] rel_id,
  output logic           rel_ready,
  input  logic           cncl_valid,
  input  logic [IDW-1:0] cncl_id,
  output logic           cncl_ready,
  input  logic           flush_req,
  output logic           flush_busy,
  output logic           criq_rable,
  input  logic [IDW-1:0] criq_pre_out,
  output logic           criq_wable,
  output logic [IDW-1:0] criq_din,
  output logic           criq_clean,
  input  logic           criq_empty,
  input  logic           criq_full,
  output logic [CW-1:0]  in_flight,
  output logic           err_flag
);

  localparam logic [CW-1:0] CNT_MAX = CW'(QDEPTH);

  lsq_state_e state, state_nxt;
  logic       serve;
  logic [1:0] gnt;
  logic       grant;
  logic       dbl_free;

  // Requests, returns and pops are only honoured in IDLE when no flush arrives this cycle
  assign serve = (state == ST_IDLE) && !flush_req;

  lsq_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({alloc_req1, alloc_req0}),
    .en    (serve && !criq_empty),
    .gnt   (gnt)
  );

  assign alloc_gnt0 = gnt[0];
  assign alloc_gnt1 = gnt[1];
  assign grant      = |gnt;
  assign criq_rable = grant;
  // The queue head is combinational, so the ID is forwarded in the grant cycle
  assign alloc_id   = grant ? criq_pre_out : '0;
  assign flush_busy = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and clean pulse; a new flush request restarts the sequence from FLUSH
  always_comb begin
    state_nxt  = state;
    criq_clean = 1'b0;
    case (state)
      ST_IDLE: begin
        if (flush_req) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        criq_clean = 1'b1;
        state_nxt  = flush_req ? ST_FLUSH : ST_SETTLE;
      end
      ST_SETTLE: begin
        state_nxt = flush_req ? ST_FLUSH : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Single write port: commit release beats speculative cancel; a full queue means a double free
  always_comb begin
    criq_wable = 1'b0;
    criq_din   = '0;
    rel_ready  = 1'b0;
    cncl_ready = 1'b0;
    dbl_free   = 1'b0;
    if (serve) begin
      if (criq_full) begin
        dbl_free = rel_valid || cncl_valid;
      end else if (rel_valid) begin
        criq_wable = 1'b1;
        criq_din   = rel_id;
        rel_ready  = 1'b1;
      end else if (cncl_valid) begin
        criq_wable = 1'b1;
        criq_din   = cncl_id;
        cncl_ready = 1'b1;
      end
    end
  end

  // Outstanding-ID counter with saturating bounds; any accounting violation is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
      err_flag  <= 1'b0;
    end else begin
      if (dbl_free) err_flag <= 1'b1;
      if (state == ST_FLUSH) begin
        in_flight <= '0;
      end else if (grant && !criq_wable) begin
        if (in_flight == CNT_MAX) err_flag <= 1'b1;
        else                      in_flight <= in_flight + CW'(1);
      end else if (criq_wable && !grant) begin
        if (in_flight == '0) err_flag <= 1'b1;
        else                 in_flight <= in_flight - CW'(1);
      end
    end
  end

endmodule
